// File: rtl/prefix_adder_pipe.sv
// rtl/prefix_adder_pipe.sv - pipelined Kogge-Stone adder, sum = a + b + cin, valid/ready handshake
// Signed-overflow output ovf is present only when PREFIX_ADDER_OVF_EN is defined.
module prefix_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PREFIX_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int L = $clog2(WIDTH + 1);

    // Vector index j holds bit position j-1, so index 0 is the carry-in position.
    logic [WIDTH:0]   gStage [0:L];
    logic [WIDTH:0]   pStage [0:L-1];
    logic [WIDTH-1:0] pBit   [0:L];
    logic [L:0]       vStage;
    logic             adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vStage <= '0;
        end else if (adv) begin
            vStage <= {vStage[L-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            gStage[0] <= {a & b, cin};
            pStage[0] <= {a ^ b, 1'b0};
            pBit[0]   <= a ^ b;
        end
    end

    for (genvar k = 1; k <= L; k++) begin : gLevel
        localparam int D = 1 << (k - 1);
        logic [WIDTH:0] gNext;

        always_comb begin
            gNext = gStage[k-1];
            for (int j = D; j <= WIDTH; j++) begin
                gNext[j] = gStage[k-1][j] | (pStage[k-1][j] & gStage[k-1][j-D]);
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                gStage[k] <= gNext;
                pBit[k]   <= pBit[k-1];
            end
        end

        // The last level needs no group propagate; gray cells (group reaches -1) force P to 0.
        if (k < L) begin : gProp
            logic [WIDTH:0] pNext;

            always_comb begin
                pNext = pStage[k-1];
                for (int j = D; j <= WIDTH; j++) begin
                    pNext[j] = (j >= 2 * D) ? (pStage[k-1][j] & pStage[k-1][j-D]) : 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    pStage[k] <= pNext;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            out_valid <= vStage[L];
            sum       <= pBit[L] ^ gStage[L][WIDTH-1:0];
            cout      <= gStage[L][WIDTH];
        end
    end

`ifdef PREFIX_ADDER_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (adv) begin
            ovf <= gStage[L][WIDTH] ^ gStage[L][WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// tb/tb_prefix_adder_pipe.sv - scoreboard bench for prefix_adder_pipe at WIDTH=16
// Checks ovf as well when PREFIX_ADDER_OVF_EN is defined.
module tb_prefix_adder_pipe;
    localparam int WIDTH = 16;
    localparam int LAT   = 7;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PREFIX_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH+1:0] expQ [$];
    logic randReady = 1'b0;

    prefix_adder_pipe #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout)
`ifdef PREFIX_ADDER_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Expected {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic c);
        longint u;
        longint s;
        logic   ov;
        u  = longint'(x) + longint'(y) + longint'(c);
        s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov = (s > ((longint'(1) << (WIDTH - 1)) - 1)) || (s < -(longint'(1) << (WIDTH - 1)));
        return {ov, u[WIDTH], u[WIDTH-1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sendBeat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                            output int stalls);
        int n;
        n = 0;
        @(posedge clk); #1;
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        stalls = n;
        if (in_ready) begin
            expQ.push_back(refModel(x, y, c));
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic latency(input string name);
        int n;
        n = 0;
        idle();
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check(name, n, LAT);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, expQ.size(), 0);
    endtask

    // Monitor: pops and compares every beat the DUT hands over.
    initial begin
        logic [WIDTH+1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", sum);
                end else begin
                    e = expQ.pop_front();
                    check("sum", sum, e[WIDTH-1:0]);
                    check("cout", cout, e[WIDTH]);
`ifdef PREFIX_ADDER_OVF_EN
                    check("ovf", ovf, e[WIDTH+1]);
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (randReady) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int st;
        int stallSum;
        int seen;
        logic [WIDTH-1:0] held;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
`ifdef PREFIX_ADDER_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        check("reset_in_ready", in_ready, 1);
        out_ready = 1'b0;
        #1 check("empty_in_ready", in_ready, 1);
        out_ready = 1'b1;

        sendBeat(16'hFFFF, 16'h0001, 1'b0, st); latency("lat_carry_chain");
        sendBeat(16'h7FFF, 16'h0001, 1'b0, st); latency("lat_signed_ovf");
        sendBeat(16'hFFFF, 16'h0000, 1'b1, st); latency("lat_cin_prop");
        sendBeat(16'h8000, 16'h8000, 1'b1, st); latency("lat_neg_ovf");
        drain("drain_directed");

        stallSum = 0;
        for (int i = 0; i < 100; i++) begin
            sendBeat(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), st);
            stallSum += st;
        end
        idle();
        check("stream_no_stall", stallSum, 0);
        drain("drain_stream");

        for (int i = 0; i < 4; i++) sendBeat(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), st);
        idle();
        out_ready = 1'b0;
        seen = 0;
        while (!out_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        check("stall_reach_output", out_valid, 1);
        held = sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_sum_stable", sum, held);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1 check("release_in_ready", in_ready, 1);
        drain("drain_stall");

        randReady = 1'b1;
        for (int i = 0; i < 60; i++) sendBeat(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), st);
        idle();
        drain("drain_backpressure");
        randReady = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        for (int i = 0; i < 9; i++) sendBeat(WIDTH'($urandom_range(1, 65535)), WIDTH'($urandom), 1'b1, st);
        idle();
        reset = 1'b1;
        expQ.delete();
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_sum", sum, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_beat", seen, 0);
        sendBeat(16'h1234, 16'h4321, 1'b1, st); latency("lat_after_reset");
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
